// File: rtl/key_step_fsm_pkg.sv
// -----------------------------------------------------------------------------
// key_step_fsm_pkg
// Shared definitions for the push-button step state machine:
//   - state type and state constants (3-bit binary, S0 = 0 .. S5 = 5)
//   - NUM_STATES and the per-key step sizes
//   - active-low 7-segment patterns (bit0 = a .. bit6 = g)
//   - add_mod6(): modular add used by the next-state logic
// -----------------------------------------------------------------------------
package key_step_fsm_pkg;

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4,
      S5 = 3'd5
   } state_e;

   localparam int NUM_STATES = 6;

   // Plain constants used by the FSM so the state register can be an
   // ordinary 3-bit vector that is also able to hold the illegal codes 6/7.
   localparam logic [2:0] ST_S0 = 3'd0;
   localparam logic [2:0] ST_S1 = 3'd1;
   localparam logic [2:0] ST_S2 = 3'd2;
   localparam logic [2:0] ST_S3 = 3'd3;
   localparam logic [2:0] ST_S4 = 3'd4;
   localparam logic [2:0] ST_S5 = 3'd5;
   localparam logic [2:0] ST_LAST = ST_S5;

   // Step sizes, expressed modulo NUM_STATES (back by one == forward by five).
   localparam logic [2:0] STEP_FWD  = 3'd1;
   localparam logic [2:0] STEP_BACK = 3'd5;
   localparam logic [2:0] STEP_JUMP = 3'd2;

   // Active-low segments, bits g..a.
   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_DASH = 7'b0111111;

   // (s + d) mod 6 for s, d in 0..5. A single conditional subtract is
   // enough because the raw sum never exceeds 10.
   function automatic logic [2:0] add_mod6(input logic [2:0] s, input logic [2:0] d);
      logic [3:0] sum;
      sum = {1'b0, s} + {1'b0, d};
      if (sum >= 4'd6) begin
         sum = sum - 4'd6;
      end
      return sum[2:0];
   endfunction

endpackage

// File: rtl/key_step_fsm_seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
// Combinational decode of a 3-bit value to an active-low 7-segment pattern.
//   value_i : 3-bit value; 0..5 show the digit, 6 and 7 show a dash
//   seg_o   : segments, bit0 = a .. bit6 = g, active-low
// -----------------------------------------------------------------------------
module seg7_decoder
   import key_step_fsm_pkg::*;
(
   input  logic [2:0] value_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      case (value_i)
         3'd0:    seg_o = SEG_0;
         3'd1:    seg_o = SEG_1;
         3'd2:    seg_o = SEG_2;
         3'd3:    seg_o = SEG_3;
         3'd4:    seg_o = SEG_4;
         3'd5:    seg_o = SEG_5;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/key_step_fsm.sv
// -----------------------------------------------------------------------------
// key_step_fsm
// Six-state Moore machine (S0..S5) stepped by three push buttons, with the
// current state shown as a digit on one 7-segment display.
//
// Parameters:
//   SYNC_STAGES : synchroniser depth on KEY[2:0], legal values 2..3
// Ports:
//   CLOCK_50 : 50 MHz system clock, rising edge
//   KEY[3]   : synchronous active-high reset (sampled directly, no sync)
//   KEY[0]   : step forward  (+1 mod 6)
//   KEY[1]   : step back     (-1 mod 6)
//   KEY[2]   : jump          (+2 mod 6)
//   HEX0     : active-low segments, bit0 = a .. bit6 = g
//
// Each key gives one action per rising edge of its synchronised level; a
// held key acts once. When several keys rise in the same cycle KEY0 wins
// over KEY1 over KEY2 and the losing edges are discarded.
// -----------------------------------------------------------------------------
module key_step_fsm
   import key_step_fsm_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLOCK_50,
   input  logic [3:0] KEY,
   output logic [6:0] HEX0
);

   logic       clk;
   logic       srst;
   logic [2:0] sync_level;
   logic [2:0] prev_q;
   logic [2:0] prev_d;
   logic [2:0] press;
   logic [2:0] state_q;
   logic [2:0] state_d;

   assign clk  = CLOCK_50;
   assign srst = KEY[3];

   // -------------------------------------------------------------------------
   // Per-key synchroniser chain. KEY enters at bit 0 and the settled level is
   // taken from the top bit.
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_sync
         logic [SYNC_STAGES-1:0] chain_q;
         logic [SYNC_STAGES-1:0] chain_d;

         assign chain_d = {chain_q[SYNC_STAGES-2:0], KEY[gi]};

         always_ff @(posedge clk) begin
            if (srst) begin
               chain_q <= '0;
            end else begin
               chain_q <= chain_d;
            end
         end

         assign sync_level[gi] = chain_q[SYNC_STAGES-1];
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Edge detect: one-cycle press pulse on each rising synchronised level.
   // prev always tracks the level, so edges that lose arbitration are
   // consumed rather than deferred.
   // -------------------------------------------------------------------------
   assign prev_d = sync_level;
   assign press  = sync_level & ~prev_q;

   always_ff @(posedge clk) begin
      if (srst) begin
         prev_q <= '0;
      end else begin
         prev_q <= prev_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic. Illegal codes recover to S0 before any key is looked
   // at; otherwise the highest-priority press picks the step size.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (state_q > ST_LAST) begin
         state_d = ST_S0;
      end else if (press[0]) begin
         state_d = add_mod6(state_q, STEP_FWD);
      end else if (press[1]) begin
         state_d = add_mod6(state_q, STEP_BACK);
      end else if (press[2]) begin
         state_d = add_mod6(state_q, STEP_JUMP);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= ST_S0;
      end else begin
         state_q <= state_d;
      end
   end

   // Display is a pure decode of the state register: no added latency.
   seg7_decoder u_seg7 (
      .value_i (state_q),
      .seg_o   (HEX0)
   );

endmodule

// File: tb/tb_key_step_fsm.sv
// -----------------------------------------------------------------------------
// tb_key_step_fsm
// Directed and randomised stimulus for key_step_fsm. The reference keeps the
// current step number as an integer and applies the +1 / -1 / +2 modulo-6
// rules with KEY0 > KEY1 > KEY2 priority; the expected display pattern comes
// from a digit table written out in the bench.
// -----------------------------------------------------------------------------
module tb_key_step_fsm;

   logic       CLOCK_50 = 1'b0;
   logic [3:0] KEY      = 4'b0000;
   logic [6:0] HEX0;

   int compared   = 0;
   int mismatched = 0;
   int model      = 0;

   key_step_fsm #(.SYNC_STAGES(2)) dut (
      .CLOCK_50 (CLOCK_50),
      .KEY      (KEY),
      .HEX0     (HEX0)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   function automatic logic [6:0] seg_of(input int n);
      case (n)
         0:       return 7'b1000000;
         1:       return 7'b1111001;
         2:       return 7'b0100100;
         3:       return 7'b0110000;
         4:       return 7'b0011001;
         5:       return 7'b0010010;
         default: return 7'b0111111;
      endcase
   endfunction

   function automatic int ref_next(input int n, input logic [2:0] mask);
      if (mask[0])      return (n + 1) % 6;
      else if (mask[1]) return (n + 5) % 6;
      else if (mask[2]) return (n + 2) % 6;
      return n;
   endfunction

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   // Press the keys in mask together, hold, release, settle, then compare.
   task automatic press_keys(input logic [2:0] mask, input int hold, input int idle,
                             input string tag);
      @(negedge CLOCK_50);
      KEY[2:0] = mask;
      cycles(hold);
      KEY[2:0] = 3'b000;
      cycles(idle);
      model = ref_next(model, mask);
      check(tag, HEX0, seg_of(model));
   endtask

   int walk_keys [11] = '{0, 2, 0, 1, 2, 1, 0, 1, 0, 1, 2};
   int walk_exp  [11] = '{1, 3, 4, 3, 5, 4, 5, 4, 5, 4, 0};

   initial begin
      logic [2:0] m;
      int h;
      int d;

      // Reset
      cycles(50);
      KEY[3] = 1'b1;
      @(posedge CLOCK_50);
      #1;
      check("reset_first_edge", HEX0, 7'b1000000);
      cycles(50);
      check("reset_held", HEX0, 7'b1000000);
      KEY[3] = 1'b0;
      cycles(5);
      model = 0;
      check("after_reset", HEX0, seg_of(model));

      // Reference walk: 1 us hold, 2 us idle
      for (int i = 0; i < 11; i++) begin
         press_keys(3'(1 << walk_keys[i]), 50, 100, $sformatf("walk%0d", i));
         check($sformatf("walk_table%0d", i), HEX0, seg_of(walk_exp[i]));
      end

      // Wrap-around (model is at 0)
      press_keys(3'b010, 5, 8, "wrap_s0_back");
      check("wrap_s0_back_seg", HEX0, 7'b0010010);
      press_keys(3'b001, 5, 8, "wrap_s5_fwd");
      press_keys(3'b010, 5, 8, "wrap_s0_back2");
      press_keys(3'b100, 5, 8, "wrap_s5_jump");
      check("wrap_s5_jump_seg", HEX0, seg_of(1));

      // Long hold gives exactly one step
      @(negedge CLOCK_50);
      KEY[0] = 1'b1;
      cycles(200);
      check("hold_during", HEX0, seg_of(2));
      KEY[0] = 1'b0;
      cycles(8);
      model = 2;
      check("hold_after", HEX0, seg_of(model));

      // Latency: display changes after the 3rd edge that samples KEY0 high
      @(negedge CLOCK_50);
      KEY[0] = 1'b1;
      @(negedge CLOCK_50);
      check("lat_edge1", HEX0, seg_of(2));
      @(negedge CLOCK_50);
      check("lat_edge2", HEX0, seg_of(2));
      @(negedge CLOCK_50);
      check("lat_edge3", HEX0, seg_of(3));
      KEY[0] = 1'b0;
      cycles(8);
      model = 3;

      // Simultaneous KEY0 + KEY2 from S2
      press_keys(3'b010, 5, 8, "to_s2");
      press_keys(3'b101, 5, 8, "simul_0_2");
      cycles(20);
      check("simul_no_late_jump", HEX0, seg_of(3));

      // Reset while KEY1 held, from S3
      @(negedge CLOCK_50);
      KEY = 4'b1010;
      cycles(5);
      check("rst_held_key", HEX0, seg_of(0));
      KEY[3] = 1'b0;
      @(negedge CLOCK_50);
      check("rst_rel_edge1", HEX0, seg_of(0));
      @(negedge CLOCK_50);
      check("rst_rel_edge2", HEX0, seg_of(0));
      @(negedge CLOCK_50);
      check("rst_rel_edge3", HEX0, seg_of(5));
      KEY[1] = 1'b0;
      cycles(8);
      model = 5;

      // Illegal state code recovers to S0
      @(negedge CLOCK_50);
      force dut.state_q = 3'd7;
      #1;
      check("illegal_dash", HEX0, 7'b0111111);
      release dut.state_q;
      @(posedge CLOCK_50);
      #1;
      check("illegal_recover", HEX0, seg_of(0));
      cycles(4);
      model = 0;

      // Randomised presses, including simultaneous combinations
      for (int i = 0; i < 40; i++) begin
         m = 3'($urandom_range(1, 7));
         h = $urandom_range(1, 6);
         d = $urandom_range(4, 9);
         press_keys(m, h, d, $sformatf("rand%0d_m%0d", i, m));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
